morphle_seq: RTL and testbench

MORPHLE_SEQ -- requirements
Module: morphle_seq

---
 rtl/morphle_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_morphle_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/morphle_seq.sv
// Command sequencer for a morphle yblock array: CLEAR / LOAD row / EVAL over a
// valid-ready command channel with one response per command.
// Optional build macro MORPHLE_SEQ_STABLE_CHECK_EN: EVAL waits for two equal consecutive samples.
module morphle_seq #(
    parameter int ROWS     = 16,
    parameter int SETTLE   = 4,
    parameter int CFG_HIGH = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic        blk_reset,
    output logic        blk_cfg,
    output logic [31:0] blk_cfg_data,
    output logic [31:0] blk_din,
    input  logic [31:0] blk_dout,
    output logic        busy
);

    localparam int RW   = $clog2(ROWS + 1);
    localparam int CMAX = SETTLE + TIMEOUT + CFG_HIGH;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_EVAL  = 2'b10;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_OVF  = 2'b01;
    localparam logic [1:0] ST_TOUT = 2'b10;
    localparam logic [1:0] ST_ILL  = 2'b11;

    typedef enum logic [2:0] {
        S_CLR,
        S_IDLE,
        S_LOAD_HI,
        S_LOAD_LO,
        S_EVAL,
        S_RSP
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [RW-1:0]   row_cnt_q;
    logic            clr_rsp_q;
    logic            blk_reset_q;
    logic            blk_cfg_q;
    logic [31:0]     cfg_data_q;
    logic [31:0]     din_q;
    logic            rsp_valid_q;
    logic [31:0]     rsp_data_q;
    logic [1:0]      rsp_status_q;
    logic            cmd_ready_q;
    logic            busy_q;
`ifdef MORPHLE_SEQ_STABLE_CHECK_EN
    logic [31:0]     prev_q;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            state_q      <= S_CLR;
            cnt_q        <= '0;
            row_cnt_q    <= '0;
            clr_rsp_q    <= 1'b0;
            blk_reset_q  <= 1'b1;
            blk_cfg_q    <= 1'b0;
            cfg_data_q   <= '0;
            din_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
`ifdef MORPHLE_SEQ_STABLE_CHECK_EN
            prev_q       <= '0;
`endif
        end else begin
            case (state_q)
                // Shared by power-up and CLEAR; only a CLEAR command owes a response.
                S_CLR: begin
                    if (cnt_q == CW'(SETTLE - 1)) begin
                        cnt_q       <= '0;
                        blk_reset_q <= 1'b0;
                        if (clr_rsp_q) begin
                            clr_rsp_q    <= 1'b0;
                            state_q      <= S_RSP;
                            rsp_valid_q  <= 1'b1;
                            rsp_status_q <= ST_OK;
                            rsp_data_q   <= '0;
                        end else begin
                            state_q     <= S_IDLE;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        case (cmd_op)
                            OP_CLEAR: begin
                                state_q     <= S_CLR;
                                clr_rsp_q   <= 1'b1;
                                blk_reset_q <= 1'b1;
                                row_cnt_q   <= '0;
                            end
                            OP_LOAD: begin
                                if (row_cnt_q < RW'(ROWS)) begin
                                    state_q    <= S_LOAD_HI;
                                    cfg_data_q <= cmd_data;
                                    blk_cfg_q  <= 1'b1;
                                end else begin
                                    state_q      <= S_RSP;
                                    rsp_valid_q  <= 1'b1;
                                    rsp_status_q <= ST_OVF;
                                    rsp_data_q   <= '0;
                                end
                            end
                            OP_EVAL: begin
                                state_q <= S_EVAL;
                                din_q   <= cmd_data;
                            end
                            default: begin
                                state_q      <= S_RSP;
                                rsp_valid_q  <= 1'b1;
                                rsp_status_q <= ST_ILL;
                                rsp_data_q   <= '0;
                            end
                        endcase
                    end
                end

                S_LOAD_HI: begin
                    if (cnt_q == CW'(CFG_HIGH - 1)) begin
                        cnt_q     <= '0;
                        blk_cfg_q <= 1'b0;
                        state_q   <= S_LOAD_LO;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_LOAD_LO: begin
                    if (cnt_q == CW'(CFG_HIGH - 1)) begin
                        cnt_q        <= '0;
                        row_cnt_q    <= row_cnt_q + RW'(1);
                        state_q      <= S_RSP;
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= ST_OK;
                        rsp_data_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_EVAL: begin
`ifdef MORPHLE_SEQ_STABLE_CHECK_EN
                    // cnt_q == SETTLE is the first sample; later ones compare against it.
                    if (cnt_q < CW'(SETTLE)) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else if (cnt_q != CW'(SETTLE) && blk_dout == prev_q) begin
                        state_q      <= S_RSP;
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= ST_OK;
                        rsp_data_q   <= blk_dout;
                    end else if (cnt_q == CW'(SETTLE + TIMEOUT - 1)) begin
                        state_q      <= S_RSP;
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= ST_TOUT;
                        rsp_data_q   <= blk_dout;
                    end else begin
                        prev_q <= blk_dout;
                        cnt_q  <= cnt_q + CW'(1);
                    end
`else
                    if (cnt_q == CW'(SETTLE - 1)) begin
                        state_q      <= S_RSP;
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= ST_OK;
                        rsp_data_q   <= blk_dout;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
`endif
                end

                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= S_CLR;
                    blk_reset_q <= 1'b1;
                    blk_cfg_q   <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_status   = rsp_status_q;
    assign blk_reset    = blk_reset_q;
    assign blk_cfg      = blk_cfg_q;
    assign blk_cfg_data = cfg_data_q;
    assign blk_din      = din_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_morphle_seq.sv
// Randomized self-checking bench for morphle_seq against a command-level model
// (row count, held registers, response latency/status/data per command).
module tb_morphle_seq;

    localparam int ROWS     = 16;
    localparam int SETTLE   = 4;
    localparam int CFG_HIGH = 2;
    localparam int TIMEOUT  = 64;

    logic        wb_clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        blk_reset;
    logic        blk_cfg;
    logic [31:0] blk_cfg_data;
    logic [31:0] blk_din;
    logic [31:0] blk_dout = '0;
    logic        busy;

    morphle_seq #(
        .ROWS(ROWS), .SETTLE(SETTLE), .CFG_HIGH(CFG_HIGH), .TIMEOUT(TIMEOUT)
    ) dut (
        .wb_clk_i(wb_clk_i), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .blk_reset(blk_reset), .blk_cfg(blk_cfg), .blk_cfg_data(blk_cfg_data),
        .blk_din(blk_din), .blk_dout(blk_dout), .busy(busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: rows loaded since clear, last cfg row, last eval input.
    int          m_rows;
    logic [31:0] m_cfg_data;
    logic [31:0] m_din;
    // dseq[j] is the blk_dout value present at the j-th edge after acceptance.
    logic [31:0] dseq [0:511];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; holds rst_n low across lo edges, then releases.
    task automatic do_reset(input int lo);
        int cnt, rv;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (lo) @(negedge wb_clk_i);
        m_rows = 0;
        m_cfg_data = '0;
        m_din = '0;
        chk("rst_blk_reset", blk_reset, 1);
        chk("rst_blk_cfg", blk_cfg, 0);
        chk("rst_cfg_data", blk_cfg_data, 0);
        chk("rst_din", blk_din, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_status", rsp_status, 0);
        chk("rst_busy", busy, 1);
        chk("rst_cmd_ready", cmd_ready, 0);
        rst_n = 1'b1;
        cnt = 0;
        rv = 0;
        while (blk_reset && cnt < 200) begin
            cnt++;
            if (rsp_valid || blk_cfg) rv++;
            @(negedge wb_clk_i);
        end
        chk("rst_hold_cycles", cnt, SETTLE);
        chk("rst_no_rsp", rv, 0);
        chk("rst_then_ready", cmd_ready, 1);
        chk("rst_then_idle", busy, 0);
    endtask

    // dmode: 0 random (with repeats), 1 constant dconst, 2 toggling dconst/~dconst.
    task automatic run_cmd(input logic [1:0] op, input logic [31:0] data,
                           input int dmode, input logic [31:0] dconst, input int stall);
        int j, exp_lat, exp_cfg, exp_rst, cfg_n, rst_cnt, both, rdy_bad, bad;
        logic [1:0]  exp_st;
        logic [31:0] exp_data, hold_d;
        logic [1:0]  hold_s;
        for (int i = 0; i < 512; i++) begin
            case (dmode)
                1: dseq[i] = dconst;
                2: dseq[i] = i[0] ? ~dconst : dconst;
                default: dseq[i] = (i > 0 && $urandom_range(0, 3) == 0) ? dseq[i-1] : $urandom;
            endcase
        end
        exp_cfg = 0; exp_rst = 0; exp_data = '0; exp_st = 2'd0; exp_lat = 0;
        case (op)
            2'd0: begin exp_lat = SETTLE; exp_rst = SETTLE; m_rows = 0; end
            2'd1: begin
                if (m_rows < ROWS) begin
                    exp_lat = 2 * CFG_HIGH; exp_cfg = CFG_HIGH; m_rows++; m_cfg_data = data;
                end else begin
                    exp_st = 2'd1;
                end
            end
            2'd2: begin
                m_din = data;
`ifdef MORPHLE_SEQ_STABLE_CHECK_EN
                exp_st = 2'd2; exp_lat = SETTLE + TIMEOUT; exp_data = dseq[SETTLE + TIMEOUT];
                for (int k = TIMEOUT; k >= 2; k--)
                    if (dseq[SETTLE + k] == dseq[SETTLE + k - 1]) begin
                        exp_st = 2'd0; exp_lat = SETTLE + k; exp_data = dseq[SETTLE + k];
                    end
`else
                exp_lat = SETTLE; exp_data = dseq[SETTLE];
`endif
            end
            default: exp_st = 2'd3;
        endcase

        j = 0;
        while (!cmd_ready && j < 100) begin
            @(negedge wb_clk_i);
            j++;
        end
        chk("cmd_ready_idle", cmd_ready, 1);
        blk_dout = dseq[0];
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_data = data;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom);
        cmd_data = $urandom;

        j = 0; cfg_n = 0; rst_cnt = 0; both = 0; rdy_bad = 0;
        while (!rsp_valid && j < 300) begin
            if (blk_cfg) cfg_n++;
            if (blk_reset) rst_cnt++;
            if (blk_cfg && blk_reset) both++;
            if (cmd_ready || !busy) rdy_bad++;
            blk_dout = dseq[j+1];
            j++;
            @(negedge wb_clk_i);
        end
        chk("rsp_latency", j, exp_lat);
        chk("rsp_status", rsp_status, exp_st);
        chk("rsp_data", rsp_data, exp_data);
        chk("cfg_pulse_cycles", cfg_n, exp_cfg);
        chk("blk_reset_cycles", rst_cnt, exp_rst);
        chk("cfg_and_reset", both, 0);
        chk("busy_not_ready", rdy_bad, 0);
        chk("blk_cfg_data", blk_cfg_data, m_cfg_data);
        chk("blk_din", blk_din, m_din);

        hold_d = rsp_data;
        hold_s = rsp_status;
        bad = 0;
        for (int s = 0; s < stall; s++) begin
            blk_dout = $urandom;
            @(negedge wb_clk_i);
            if (!rsp_valid || rsp_data !== hold_d || rsp_status !== hold_s || cmd_ready) bad++;
        end
        chk("rsp_stall_stable", bad, 0);
        rsp_ready = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready = 1'b0;
        chk("post_hs_rsp_valid", rsp_valid, 0);
        chk("post_hs_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        int r, cnt;
        do_reset(2);

        run_cmd(2'd1, 32'hA5A5_0F0F, 0, '0, 0);
        chk("load_a5_cfg_data", blk_cfg_data, 32'hA5A5_0F0F);

        // Fill to capacity and one past, then recover with CLEAR.
        run_cmd(2'd0, $urandom, 0, '0, 1);
        for (int i = 0; i < ROWS + 1; i++) run_cmd(2'd1, $urandom, 0, '0, $urandom_range(0, 2));
        run_cmd(2'd0, $urandom, 0, '0, 0);
        run_cmd(2'd1, 32'hCAFE_0001, 0, '0, 0);

        run_cmd(2'd2, 32'h0000_0003, 1, 32'h1234_5678, 5);
        run_cmd(2'd3, $urandom, 0, '0, 0);
        run_cmd(2'd2, 32'h0000_0007, 2, 32'h0F0F_F0F0, 1);
        run_cmd(2'd2, 32'h0000_0009, 1, 32'hDEAD_BEEF, 0);

        // Abort a LOAD while blk_cfg is high.
        cnt = 0;
        while (!cmd_ready && cnt < 100) begin @(negedge wb_clk_i); cnt++; end
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 32'h5555_AAAA;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        chk("abort_in_load_hi", blk_cfg, 1);
        rst_n = 1'b0;
        @(negedge wb_clk_i);
        chk("abort_cfg_low", blk_cfg, 0);
        chk("abort_reset_high", blk_reset, 1);
        do_reset(0);
        cnt = 0;
        repeat (12) begin
            @(negedge wb_clk_i);
            if (rsp_valid) cnt++;
        end
        chk("abort_no_rsp", cnt, 0);
        for (int i = 0; i < ROWS + 1; i++) run_cmd(2'd1, $urandom, 0, '0, 0);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 99);
            run_cmd(r < 5 ? 2'd0 : r < 55 ? 2'd1 : r < 85 ? 2'd2 : 2'd3,
                    $urandom, 0, '0, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
